ahb_sram_slave_if: RTL and testbench



---
 rtl/ahb_sram_slave_if_pkg.sv | 36 +++
 rtl/ahb_sram_slave_if.sv | 129 ++++++++++++
 tb/tb_ahb_sram_slave_if.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if_pkg.sv
// Shared definitions for the AHB-Lite SRAM slave front end: bus codes,
// controller state encoding and the transfer-legality rule.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    // Byte, naturally aligned half-word and naturally aligned word only.
    function automatic logic legal_xfer(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lo[0];
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave front end: turns AHB address/data phases into single-pulse
// SRAM controller requests, inserting wait states until the controller acks.
module ahb_sram_slave_if
    import ahb_sram_pkg::*;
#(
    parameter int unsigned AHB_DWIDTH  = 32,
    parameter int unsigned SRAM_AWIDTH = 20
) (
    input  logic                   HCLK,
    input  logic                   aresetn,
    input  logic                   HSEL,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [AHB_DWIDTH-1:0]  HWDATA,
    input  logic                   HREADYIN,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [AHB_DWIDTH-1:0]  HRDATA,
    output logic                   sram_req,
    output logic                   sram_write,
    output logic [2:0]             sram_size,
    output logic [SRAM_AWIDTH-1:0] sram_addr,
    output logic [AHB_DWIDTH-1:0]  sram_wdata,
    input  logic                   sram_ack,
    input  logic [AHB_DWIDTH-1:0]  sram_rdata,
    input  logic                   sram_busy
);

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_open;
    logic                   w_accept;
    logic                   w_legal;
    logic                   w_hready;
    logic                   w_hresp;
    logic                   w_req;
    logic [SRAM_AWIDTH-1:0] r_addr;
    logic [2:0]             r_size;
    logic                   r_write;
    logic [AHB_DWIDTH-1:0]  r_wdata;
    logic [AHB_DWIDTH-1:0]  r_hrdata;
    logic                   w_unused;

    assign w_unused = ^{HTRANS[0], HADDR[31:SRAM_AWIDTH]};

    // A new address phase is only sampled in states that drive HREADYOUT high.
    assign w_open   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
    assign w_accept = w_open & HSEL & HREADYIN & HTRANS[1];
    assign w_legal  = legal_xfer(HSIZE, HADDR[1:0]);

    always_comb begin
        w_next   = r_state;
        w_hready = 1'b1;
        w_hresp  = 1'b0;
        w_req    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR2: begin
                w_hresp = (r_state == S_ERR2);
                if (w_accept) begin
                    if (!w_legal)
                        w_next = S_ERR1;
                    else if (HWRITE)
                        w_next = S_WDATA;
                    else
                        w_next = S_REQ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WDATA: begin
                w_hready = 1'b0;
                w_next   = S_REQ;
            end
            S_REQ: begin
                w_hready = 1'b0;
                if (!sram_busy) begin
                    w_req  = 1'b1;
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_hready = 1'b0;
                if (sram_ack)
                    w_next = S_DONE;
            end
            S_ERR1: begin
                w_hready = 1'b0;
                w_hresp  = 1'b1;
                w_next   = S_ERR2;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_size   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_hrdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= HADDR[SRAM_AWIDTH-1:0];
                r_size  <= HSIZE;
                r_write <= HWRITE;
            end
            if (r_state == S_WDATA)
                r_wdata <= HWDATA;
            // Acks are honoured only while a request is outstanding.
            if ((r_state == S_WAIT) && sram_ack && !r_write)
                r_hrdata <= sram_rdata;
        end
    end

    assign HREADYOUT  = w_hready;
    assign HRESP      = w_hresp;
    assign HRDATA     = r_hrdata;
    assign sram_req   = w_req;
    assign sram_write = r_write;
    assign sram_size  = r_size;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;

endmodule

// File: tb/tb_ahb_sram_slave_if.sv
// Bench for ahb_sram_slave_if: transaction-level AHB model plus SRAM
// controller model, checked every cycle, with literal pins on key results.
module tb_ahb_sram_slave_if;
    import ahb_sram_pkg::*;

    localparam int unsigned AW = 20;

    logic          HCLK = 1'b0;
    logic          aresetn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADYIN;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic          sram_req;
    logic          sram_write;
    logic [2:0]    sram_size;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic          sram_ack;
    logic [31:0]   sram_rdata;
    logic          sram_busy;
    logic          ack_model;
    logic          ack_spur;

    assign HREADYIN = HREADYOUT;
    assign sram_ack = ack_model | ack_spur;

    ahb_sram_slave_if #(.AHB_DWIDTH(32), .SRAM_AWIDTH(AW)) dut (
        .HCLK(HCLK), .aresetn(aresetn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .sram_req(sram_req),
        .sram_write(sram_write), .sram_size(sram_size), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_ack(sram_ack), .sram_rdata(sram_rdata),
        .sram_busy(sram_busy)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0]  addr;
        logic         write;
        logic [2:0]   size;
        logic [31:0]  wdata;
        int unsigned  busy;
    } xfer_t;

    xfer_t        exp_q[$];
    logic [31:0]  ref_mem  [logic [AW-1:0]];
    logic [31:0]  ctrl_mem [logic [AW-1:0]];
    int           n_chk = 0;
    int           n_fail = 0;

    xfer_t        cur;
    bit           active = 0;
    int unsigned  cnt, w, reqs;
    logic [31:0]  last_read = '0;

    function automatic logic [31:0] dflt(input logic [AW-1:0] a);
        return {12'hA5A, a};
    endfunction

    function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ctrl_read(input logic [AW-1:0] a);
        return ctrl_mem.exists(a) ? ctrl_mem[a] : dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM controller: one-cycle ack after each request.
    initial begin
        logic [AW-1:0] a;
        logic          wr;
        logic [31:0]   d;
        ack_model  = 1'b0;
        sram_rdata = '0;
        forever begin
            @(negedge HCLK);
            if (aresetn && sram_req) begin
                a = sram_addr; wr = sram_write; d = sram_wdata;
                @(posedge HCLK); #1;
                ack_model = 1'b1;
                if (wr) ctrl_mem[a] = d;
                else    sram_rdata = ctrl_read(a);
                @(posedge HCLK); #1;
                ack_model = 1'b0;
            end
        end
    end

    // Per-cycle compare against the transaction-level expectation.
    initial begin
        forever begin
            @(negedge HCLK);
            if (!aresetn) begin
                check("rst_hready", 32'(HREADYOUT), 32'd1);
                check("rst_hresp", 32'(HRESP), 32'd0);
                check("rst_hrdata", HRDATA, 32'd0);
                check("rst_req", 32'(sram_req), 32'd0);
                check("rst_write", 32'(sram_write), 32'd0);
                check("rst_size", 32'(sram_size), 32'd0);
                check("rst_addr", 32'(sram_addr), 32'd0);
                check("rst_wdata", sram_wdata, 32'd0);
                active    = 0;
                last_read = '0;
            end else begin
                if (active) cnt++;
                if (sram_req) begin
                    check("req_busy", 32'(sram_busy), 32'd0);
                    check("req_expected", 32'(active && legal_xfer(cur.size, cur.addr[1:0])), 32'd1);
                    if (active) begin
                        check("req_cycle", cnt, (cur.write ? 32'd2 : 32'd1) + cur.busy);
                        check("req_addr", 32'(sram_addr), 32'(cur.addr[AW-1:0]));
                        check("req_size", 32'(sram_size), 32'(cur.size));
                        check("req_write", 32'(sram_write), 32'(cur.write));
                        if (cur.write) check("req_wdata", sram_wdata, cur.wdata);
                        reqs++;
                    end
                end
                if (sram_ack && active && reqs > 0) begin
                    check("ack_addr_stable", 32'(sram_addr), 32'(cur.addr[AW-1:0]));
                    check("ack_write_stable", 32'(sram_write), 32'(cur.write));
                    if (cur.write) check("ack_wdata_stable", sram_wdata, cur.wdata);
                end
                if (active) begin
                    check("hready", 32'(HREADYOUT), 32'(cnt == w + 1));
                    check("hresp", 32'(HRESP), 32'(!legal_xfer(cur.size, cur.addr[1:0])));
                    if (cnt >= w + 1) begin
                        if (legal_xfer(cur.size, cur.addr[1:0])) begin
                            check("req_count", reqs, 32'd1);
                            if (cur.write) begin
                                ref_mem[cur.addr[AW-1:0]] = cur.wdata;
                                check("hrdata_hold", HRDATA, last_read);
                            end else begin
                                last_read = ref_read(cur.addr[AW-1:0]);
                                check("hrdata_read", HRDATA, last_read);
                            end
                        end else begin
                            check("err_no_req", reqs, 32'd0);
                            check("hrdata_hold", HRDATA, last_read);
                        end
                        active = 0;
                    end else begin
                        check("hrdata_hold", HRDATA, last_read);
                    end
                end else begin
                    check("idle_hready", 32'(HREADYOUT), 32'd1);
                    check("idle_hresp", 32'(HRESP), 32'd0);
                    check("idle_hrdata", HRDATA, last_read);
                end
                if (HSEL && HTRANS[1] && HREADYOUT) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_accept", 32'd1, 32'd0);
                    end else begin
                        cur    = exp_q.pop_front();
                        active = 1;
                        cnt    = 0;
                        reqs   = 0;
                        w      = legal_xfer(cur.size, cur.addr[1:0])
                                 ? ((cur.write ? 3 : 2) + cur.busy) : 1;
                    end
                end
            end
        end
    end

    task automatic idle(input int unsigned n);
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; sram_busy = 1'b0; ack_spur = 1'b0;
        repeat (n) begin @(posedge HCLK); #1; end
    endtask

    // Drives one address phase now and returns in its completion cycle, so
    // consecutive calls pipeline the next address into the completing cycle.
    task automatic xfer(input string name, input logic [31:0] a, input logic wr,
                        input logic [2:0] sz, input logic [31:0] wd, input int unsigned busy,
                        input logic spur, input int unsigned exp_w);
        xfer_t       r;
        int unsigned waits, rq;
        bit          done;
        r.addr = a; r.write = wr; r.size = sz; r.wdata = wd; r.busy = busy;
        exp_q.push_back(r);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = a; HWRITE = wr; HSIZE = sz;
        sram_busy = 1'b0; ack_spur = 1'b0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = wd;
        rq = wr ? 2 : 1; waits = 0; done = 0;
        for (int unsigned k = 1; k <= 40 && !done; k++) begin
            sram_busy = (k >= rq) && (k < rq + busy);
            ack_spur  = spur && (k == 1);
            if (HREADYOUT) done = 1;
            else begin
                waits++;
                @(posedge HCLK); #1;
            end
        end
        sram_busy = 1'b0; ack_spur = 1'b0;
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_waits"}, waits, exp_w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
        HSIZE = HSIZE_WORD; HWDATA = '0; sram_busy = 1'b0; ack_spur = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        check("pin_rst_hready", 32'(HREADYOUT), 32'd1);
        aresetn = 1'b1;
        idle(2);

        xfer("wr_word", 32'h0000_0010, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 0, 1'b0, 3);
        check("pin_wr_addr", 32'(sram_addr), 32'h0000_0010);
        check("pin_wr_wdata", sram_wdata, 32'hDEAD_BEEF);
        idle(2);
        xfer("rd_word", 32'h0000_0010, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 2);
        check("pin_rd_data", HRDATA, 32'hDEAD_BEEF);
        idle(1);

        xfer("wr_byte", 32'h0000_0013, 1'b1, HSIZE_BYTE, 32'hAB00_0000, 0, 1'b1, 3);
        check("pin_byte_addr", 32'(sram_addr), 32'h0000_0013);
        check("pin_byte_size", 32'(sram_size), 32'd0);
        check("pin_byte_wdata", sram_wdata, 32'hAB00_0000);
        check("pin_byte_hresp", 32'(HRESP), 32'd0);
        idle(1);

        xfer("wr_busy", 32'h0000_0020, 1'b1, HSIZE_WORD, 32'h1234_5678, 5, 1'b0, 8);
        idle(1);
        xfer("rd_busy", 32'h0000_0020, 1'b0, HSIZE_WORD, 32'h0, 5, 1'b0, 7);
        check("pin_busy_data", HRDATA, 32'h1234_5678);
        idle(1);

        xfer("b2b_rd", 32'h0000_0010, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 2);
        xfer("b2b_wr", 32'h0000_0014, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, 0, 1'b0, 3);
        xfer("b2b_rd2", 32'h0000_0014, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 2);
        check("pin_b2b_data", HRDATA, 32'hCAFE_F00D);
        xfer("rd_half", 32'h0000_0012, 1'b0, HSIZE_HALF, 32'h0, 0, 1'b0, 2);
        check("pin_half_data", HRDATA, 32'hA5A0_0012);
        idle(1);

        HSEL = 1'b1; HTRANS = HTRANS_BUSY; HADDR = 32'h0000_0001; HSIZE = 3'd3;
        @(posedge HCLK); #1;
        ack_spur = 1'b1; HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        @(posedge HCLK); #1;
        ack_spur = 1'b0;
        idle(1);

        xfer("err_half", 32'h0000_0001, 1'b0, HSIZE_HALF, 32'h0, 0, 1'b0, 1);
        check("pin_err_hresp", 32'(HRESP), 32'd1);
        xfer("err_size", 32'h0000_0000, 1'b1, 3'd3, 32'h0, 0, 1'b0, 1);
        check("pin_err2_hresp", 32'(HRESP), 32'd1);
        xfer("after_err", 32'h0000_0010, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 2);
        check("pin_after_err", HRDATA, 32'hDEAD_BEEF);
        idle(1);

        begin
            xfer_t r;
            r.addr = 32'h0000_0010; r.write = 1'b0; r.size = HSIZE_WORD; r.wdata = '0; r.busy = 0;
            exp_q.push_back(r);
            HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = r.addr; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
            @(posedge HCLK); #1;
            HSEL = 1'b0; HTRANS = HTRANS_IDLE;
            check("pin_rst_req_issued", 32'(sram_req), 32'd1);
            @(posedge HCLK); #1;
            check("pin_wait_hready", 32'(HREADYOUT), 32'd0);
            #2 aresetn = 1'b0;
            #1;
            check("pin_midrst_hready", 32'(HREADYOUT), 32'd1);
            check("pin_midrst_hresp", 32'(HRESP), 32'd0);
            check("pin_midrst_req", 32'(sram_req), 32'd0);
            check("pin_midrst_hrdata", HRDATA, 32'd0);
            @(posedge HCLK); #2;
            aresetn = 1'b1;
            @(posedge HCLK); #1;
        end

        xfer("rd_after_rst", 32'h0000_0014, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 2);
        check("pin_after_rst", HRDATA, 32'hCAFE_F00D);
        idle(3);
        check("drain_queue", exp_q.size(), 32'd0);
        check("drain_active", 32'(active), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
